// File: rtl/subtrator_sequencial.sv
// Digit-serial subtractor S = A - B - Bin, DIGIT bits per clock, start/busy/done handshake.
// Optional Z/V flags when SUBTRATOR_SEQUENCIAL_FLAGS_EN is defined.
module subtrator_sequencial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Bout,
  output logic             Z,
  output logic             V
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("subtrator_sequencial: DIGIT must divide WIDTH");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, part_q, res;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;
  logic [DIGIT-1:0] a_dig, b_dig, d;
  logic             b_out;
  logic             last;

  assign last = (cnt_q == CW'(N - 1));
  assign busy = (state == RUN);

  // One digit of ripple subtract; the MSB of the extended difference is the borrow.
  always_comb begin
    a_dig = a_q[cnt_q*DIGIT +: DIGIT];
    b_dig = b_q[cnt_q*DIGIT +: DIGIT];
    {b_out, d} = {1'b0, a_dig} - {1'b0, b_dig}
               - {{DIGIT{1'b0}}, borrow_q};
    res = part_q;
    res[cnt_q*DIGIT +: DIGIT] = d;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      S        <= '0;
      Bout     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= Bin;
            cnt_q    <= '0;
            part_q   <= '0;
          end
        end
        RUN: begin
          part_q   <= res;
          borrow_q <= b_out;
          cnt_q    <= last ? '0 : cnt_q + 1'b1;
          if (last) begin
            S    <= res;
            Bout <= b_out;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SUBTRATOR_SEQUENCIAL_FLAGS_EN
  logic z_q, v_q;

  // Flags use the complete result, Bin already folded in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q <= 1'b0;
      v_q <= 1'b0;
    end else if (state == RUN && last) begin
      z_q <= (res == '0);
      v_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
             (res[WIDTH-1] != a_q[WIDTH-1]);
    end
  end

  assign Z = z_q;
  assign V = v_q;
`else
  assign Z = 1'b0;
  assign V = 1'b0;
`endif

endmodule
